// File: rtl/rf_wr_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter:
// the arbiter FSM state and the long-latency result queue entry.
package rf_wr_arbiter_pkg;

    localparam int NUM_ARCH_REGS = 32;
    localparam int REG_AW        = $clog2(NUM_ARCH_REGS);
    localparam int XLEN          = 32;

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } lq_entry_t;

endpackage

// File: rtl/rf_wr_lq.sv
// Circular FIFO holding long-latency results until the RF write port is free.
// Pointers carry a wrap bit, so count = wr_ptr - rd_ptr covers 0..DEPTH.
module rf_wr_lq
    import rf_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  lq_entry_t                push_entry,
    input  logic                     pop,
    output lq_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    lq_entry_t   mem [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Arbitrates the single RF write port between in-order writeback and queued
// long-latency results; tracks pending destinations and stalls to drain the queue.
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int LQ_DEPTH   = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_wr_en_i,
    input  logic [REG_AW-1:0]        wb_wr_reg_i,
    input  logic [XLEN-1:0]          wb_wr_data_i,
    input  logic                     ll_issue_i,
    input  logic [REG_AW-1:0]        ll_issue_rd_i,
    input  logic                     ll_valid_i,
    input  logic [REG_AW-1:0]        ll_rd_i,
    input  logic [XLEN-1:0]          ll_data_i,
    output logic                     ll_ready_o,
    output logic                     rf_wr_en_o,
    output logic [REG_AW-1:0]        rf_wr_reg_o,
    output logic [XLEN-1:0]          rf_wr_data_o,
    output logic                     rf_wr_src_lq_o,
    output logic [NUM_ARCH_REGS-1:0] busy_o,
    output logic                     wb_stall_o
);

    localparam int CW = $clog2(LQ_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e              state, state_next;
    logic [SW-1:0]           starve_cnt, starve_next;
    logic [NUM_ARCH_REGS-1:0] busy_q, busy_next;
    logic                    stall_q;

    lq_entry_t               lq_head;
    lq_entry_t               lq_push_entry;
    logic                    lq_full, lq_empty, lq_push, lq_pop;
    logic [CW-1:0]           lq_count, lq_count_next;
    logic                    lq_denied;

    assign lq_push_entry = '{rd: ll_rd_i, data: ll_data_i};
    assign ll_ready_o    = !lq_full && (state == NORMAL);
    assign lq_push       = ll_valid_i && ll_ready_o;
    assign lq_denied     = (state == NORMAL) && wb_wr_en_i && !lq_empty;
    assign lq_count_next = lq_count + CW'(lq_push) - CW'(lq_pop);
    assign busy_o        = busy_q;
    assign wb_stall_o    = stall_q;

    rf_wr_lq #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk        (clk),
        .rst        (rst),
        .push       (lq_push),
        .push_entry (lq_push_entry),
        .pop        (lq_pop),
        .head       (lq_head),
        .full       (lq_full),
        .empty      (lq_empty),
        .count      (lq_count)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rf_wr_en_o     = 1'b0;
        rf_wr_reg_o    = wb_wr_reg_i;
        rf_wr_data_o   = wb_wr_data_i;
        rf_wr_src_lq_o = 1'b0;
        lq_pop         = 1'b0;
        if (state == NORMAL && wb_wr_en_i) begin
            rf_wr_en_o = 1'b1;
        end else if (!lq_empty) begin
            // x0 entries still leave the queue but never reach the RF
            lq_pop         = 1'b1;
            rf_wr_src_lq_o = 1'b1;
            rf_wr_reg_o    = lq_head.rd;
            rf_wr_data_o   = lq_head.data;
            rf_wr_en_o     = (lq_head.rd != '0);
        end
        if (rst) rf_wr_en_o = 1'b0;
    end

    always_comb begin
        state_next = state;
        case (state)
            NORMAL: begin
                if (lq_count_next == CW'(LQ_DEPTH) ||
                    (lq_denied && starve_cnt == SW'(STARVE_MAX - 1)))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if ((lq_count == CW'(1) && lq_pop) || lq_empty)
                    state_next = NORMAL;
            end
            default: state_next = NORMAL;
        endcase
    end

    always_comb begin
        starve_next = starve_cnt;
        if (lq_pop || state == DRAIN)
            starve_next = '0;
        else if (lq_denied && starve_cnt != SW'(STARVE_MAX))
            starve_next = starve_cnt + 1'b1;
    end

    // A fresh issue to the same register outranks the clear from the older result.
    always_comb begin
        busy_next = busy_q;
        if (lq_pop && lq_head.rd != '0)
            busy_next[lq_head.rd] = 1'b0;
        if (ll_issue_i && ll_issue_rd_i != '0)
            busy_next[ll_issue_rd_i] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NORMAL;
            starve_cnt <= '0;
            busy_q     <= '0;
            stall_q    <= 1'b0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            busy_q     <= busy_next;
            stall_q    <= (state_next == DRAIN);
        end
    end

endmodule
